// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_AUX_BURST = 2'd1,
    ST_RELEASE   = 2'd2
  } arb_state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_AUX = 1'b1;

  localparam int DEF_ADDR_W    = 12;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_MAX_BURST = 8;

  // Bits needed to hold a burst count from 0 up to max_val inclusive
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin pick with last-grant memory
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic req_cpu,
  input  logic req_aux,
  input  logic upd_valid,
  input  logic upd_id,
  output logic pick_valid,
  output logic pick_id
);

  logic last_gnt;

  // Remember who was served most recently; aux after reset so cpu wins the first tie
  always_ff @(posedge clock) begin
    if (reset) begin
      last_gnt <= REQ_AUX;
    end else if (upd_valid) begin
      last_gnt <= upd_id;
    end
  end

  // A lone requester wins outright; a tie goes to whoever was not served last
  always_comb begin
    pick_valid = req_cpu | req_aux;
    if (req_cpu && req_aux) begin
      pick_id = ~last_gnt;
    end else if (req_aux) begin
      pick_id = REQ_AUX;
    end else begin
      pick_id = REQ_CPU;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the single-port data RAM between cpu and aux masters
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wEn,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_dataIn,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_dataOut,
  input  logic              aux_req,
  input  logic              aux_wEn,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_dataIn,
  input  logic              aux_lock,
  output logic              aux_gnt,
  output logic              aux_rvalid,
  output logic [DATA_W-1:0] aux_dataOut,
  output logic              ram_wEn,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dataIn,
  input  logic [DATA_W-1:0] ram_dataOut
);

  localparam int               CNT_W    = cnt_width(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  arb_state_t       state;
  logic [CNT_W-1:0] burst_cnt;
  logic             rd_pend;
  logic             rd_owner;
  logic             rr_valid;
  logic             rr_id;
  logic             gnt_cpu;
  logic             gnt_aux;
  logic             burst_go;

  rr_arbiter2 u_rr (
    .clock      (clock),
    .reset      (reset),
    .req_cpu    (cpu_req),
    .req_aux    (aux_req),
    .upd_valid  (gnt_cpu | gnt_aux),
    .upd_id     (gnt_aux),
    .pick_valid (rr_valid),
    .pick_id    (rr_id)
  );

  // Grant decision from the live requests and the registered arbitration state
  always_comb begin
    gnt_cpu  = 1'b0;
    gnt_aux  = 1'b0;
    burst_go = aux_req && aux_lock && (burst_cnt < CNT_MAX);
    if (!reset) begin
      case (state)
        ST_IDLE: begin
          gnt_cpu = rr_valid && (rr_id == REQ_CPU);
          gnt_aux = rr_valid && (rr_id == REQ_AUX);
        end
        ST_AUX_BURST: begin
          // The cycle that ends a burst early never serves aux; cpu may use it
          gnt_aux = burst_go;
          gnt_cpu = !burst_go && cpu_req;
        end
        ST_RELEASE: begin
          gnt_cpu = cpu_req;
          gnt_aux = aux_req && !cpu_req;
        end
        default: begin
          gnt_cpu = 1'b0;
          gnt_aux = 1'b0;
        end
      endcase
    end
  end

  // Route the winner's command onto the RAM; an idle bus is driven to zero
  always_comb begin
    ram_wEn    = 1'b0;
    ram_addr   = '0;
    ram_dataIn = '0;
    if (gnt_cpu) begin
      ram_wEn    = cpu_wEn;
      ram_addr   = cpu_addr;
      ram_dataIn = cpu_dataIn;
    end else if (gnt_aux) begin
      ram_wEn    = aux_wEn;
      ram_addr   = aux_addr;
      ram_dataIn = aux_dataIn;
    end
  end

  assign cpu_gnt     = gnt_cpu;
  assign aux_gnt     = gnt_aux;
  assign cpu_stall   = cpu_req && !gnt_cpu && !reset;
  assign cpu_rvalid  = !reset && rd_pend && (rd_owner == REQ_CPU);
  assign aux_rvalid  = !reset && rd_pend && (rd_owner == REQ_AUX);
  assign cpu_dataOut = cpu_rvalid ? ram_dataOut : '0;
  assign aux_dataOut = aux_rvalid ? ram_dataOut : '0;

  // Burst FSM, burst counter and read-return tracking
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      burst_cnt <= '0;
      rd_pend   <= 1'b0;
      rd_owner  <= REQ_CPU;
    end else begin
      rd_pend <= (gnt_cpu && !cpu_wEn) || (gnt_aux && !aux_wEn);
      if (gnt_cpu || gnt_aux) begin
        rd_owner <= gnt_aux ? REQ_AUX : REQ_CPU;
      end
      case (state)
        ST_IDLE: begin
          if (gnt_aux && aux_lock) begin
            burst_cnt <= CNT_ONE;
            state     <= (MAX_BURST == 1) ? ST_RELEASE : ST_AUX_BURST;
          end
        end
        ST_AUX_BURST: begin
          if (gnt_aux) begin
            burst_cnt <= burst_cnt + CNT_ONE;
            // Leave straight after the last allowed grant so cpu is served next cycle
            if (burst_cnt == CNT_LAST) begin
              state <= ST_RELEASE;
            end
          end else begin
            burst_cnt <= '0;
            state     <= ST_IDLE;
          end
        end
        ST_RELEASE: begin
          burst_cnt <= '0;
          state     <= ST_IDLE;
        end
        default: begin
          burst_cnt <= '0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int MB = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_wEn, aux_req, aux_wEn, aux_lock;
  logic [AW-1:0] cpu_addr, aux_addr, ram_addr;
  logic [DW-1:0] cpu_dataIn, aux_dataIn, ram_dataIn, ram_dataOut;
  logic          cpu_gnt, cpu_stall, cpu_rvalid, aux_gnt, aux_rvalid, ram_wEn;
  logic [DW-1:0] cpu_dataOut, aux_dataOut;

  always #5 clock = ~clock;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_wEn(cpu_wEn), .cpu_addr(cpu_addr), .cpu_dataIn(cpu_dataIn),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_dataOut(cpu_dataOut),
    .aux_req(aux_req), .aux_wEn(aux_wEn), .aux_addr(aux_addr), .aux_dataIn(aux_dataIn),
    .aux_lock(aux_lock), .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid), .aux_dataOut(aux_dataOut),
    .ram_wEn(ram_wEn), .ram_addr(ram_addr), .ram_dataIn(ram_dataIn), .ram_dataOut(ram_dataOut)
  );

  // Behavioural single-port RAM with one-cycle read latency
  logic [DW-1:0] ram [int];
  always @(posedge clock) begin
    logic [DW-1:0] rd;
    rd = ram.exists(int'(ram_addr)) ? ram[int'(ram_addr)] : '0;
    if (ram_wEn) ram[int'(ram_addr)] = ram_dataIn;
    ram_dataOut <= rd;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: who may use the memory, per the arbitration rules
  logic [DW-1:0] shadow [int];
  bit            m_last_aux;
  int            m_run;
  bit            m_rel;
  bit            m_rd_pend, m_rd_aux;
  logic [DW-1:0] m_rd_data;

  bit            s_cg, s_ag, s_stall, s_crv, s_arv;
  logic [DW-1:0] s_cdo, s_ado;

  function automatic logic [DW-1:0] sh_rd(input logic [AW-1:0] a);
    return shadow.exists(int'(a)) ? shadow[int'(a)] : '0;
  endfunction

  task automatic run_cycle(output bit gc, output bit ga);
    logic [DW-1:0] ecdo, eado;
    gc = 0;
    ga = 0;
    @(negedge clock);
    s_cg = cpu_gnt; s_ag = aux_gnt; s_stall = cpu_stall;
    s_crv = cpu_rvalid; s_arv = aux_rvalid; s_cdo = cpu_dataOut; s_ado = aux_dataOut;
    if (reset) begin
      chk("reset_ctl", {cpu_gnt, aux_gnt, cpu_stall, cpu_rvalid, aux_rvalid, ram_wEn}, 128'd0);
      chk("reset_bus", {ram_addr, ram_dataIn, cpu_dataOut, aux_dataOut}, 128'd0);
      m_last_aux = 1; m_run = 0; m_rel = 0; m_rd_pend = 0;
    end else begin
      if (m_rel) begin
        gc = cpu_req;
        ga = aux_req && !cpu_req;
      end else if (m_run > 0) begin
        if (aux_req && aux_lock && m_run < MB) ga = 1;
        else gc = cpu_req;
      end else if (cpu_req && aux_req) begin
        if (m_last_aux) gc = 1;
        else ga = 1;
      end else begin
        gc = cpu_req;
        ga = aux_req;
      end
      chk("gnt", {cpu_gnt, aux_gnt, cpu_stall}, {gc, ga, cpu_req && !gc});
      if (gc)      chk("ram", {ram_wEn, ram_addr, ram_dataIn}, {cpu_wEn, cpu_addr, cpu_dataIn});
      else if (ga) chk("ram", {ram_wEn, ram_addr, ram_dataIn}, {aux_wEn, aux_addr, aux_dataIn});
      else         chk("ram", {ram_wEn, ram_addr, ram_dataIn}, 128'd0);
      ecdo = (m_rd_pend && !m_rd_aux) ? m_rd_data : '0;
      eado = (m_rd_pend && m_rd_aux) ? m_rd_data : '0;
      chk("rdata", {cpu_rvalid, cpu_dataOut, aux_rvalid, aux_dataOut},
          {m_rd_pend && !m_rd_aux, ecdo, m_rd_pend && m_rd_aux, eado});
      if (gc || ga) m_last_aux = ga;
      if (m_rel) begin
        m_rel = 0;
        m_run = 0;
      end else if (m_run > 0) begin
        if (ga) begin
          m_run++;
          if (m_run == MB) m_rel = 1;
        end else begin
          m_run = 0;
        end
      end else if (ga && aux_lock) begin
        m_run = 1;
        if (MB == 1) m_rel = 1;
      end
      m_rd_pend = (gc && !cpu_wEn) || (ga && !aux_wEn);
      m_rd_aux  = ga;
      m_rd_data = gc ? sh_rd(cpu_addr) : sh_rd(aux_addr);
      if (gc && cpu_wEn) shadow[int'(cpu_addr)] = cpu_dataIn;
      if (ga && aux_wEn) shadow[int'(aux_addr)] = aux_dataIn;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_wEn = 0; cpu_addr = '0; cpu_dataIn = '0;
    aux_req = 0; aux_wEn = 0; aux_addr = '0; aux_dataIn = '0; aux_lock = 0;
  endtask

  task automatic do_reset();
    bit gc, ga;
    reset = 1;
    idle_inputs();
    run_cycle(gc, ga);
    reset = 0;
  endtask

  typedef struct {
    bit cr; bit cw; logic [AW-1:0] ca; logic [DW-1:0] cd;
    bit ar; bit aw; bit al; logic [AW-1:0] aa; logic [DW-1:0] ad;
    bit ecg; bit eag; bit ecrv; logic [DW-1:0] ecdo; bit earv; logic [DW-1:0] eado;
  } vec_t;

  vec_t vt [12];

  initial begin
    bit gc, ga, got, cp, ap;
    int run, stall_cnt;

    vt[0]  = '{1, 1, 12'h010, 32'hDEADBEEF, 0, 0, 0, 12'h000, 32'h0,        1, 0, 0, 32'h0,        0, 32'h0};
    vt[1]  = '{1, 0, 12'h010, 32'h0,        0, 0, 0, 12'h000, 32'h0,        1, 0, 0, 32'h0,        0, 32'h0};
    vt[2]  = '{0, 0, 12'h000, 32'h0,        0, 0, 0, 12'h000, 32'h0,        0, 0, 1, 32'hDEADBEEF, 0, 32'h0};
    vt[3]  = '{0, 0, 12'h000, 32'h0,        1, 1, 0, 12'h020, 32'hA5A50020, 0, 1, 0, 32'h0,        0, 32'h0};
    vt[4]  = '{1, 0, 12'h010, 32'h0,        1, 0, 0, 12'h020, 32'h0,        1, 0, 0, 32'h0,        0, 32'h0};
    vt[5]  = '{1, 0, 12'h010, 32'h0,        1, 0, 0, 12'h020, 32'h0,        0, 1, 1, 32'hDEADBEEF, 0, 32'h0};
    vt[6]  = '{1, 0, 12'h010, 32'h0,        1, 0, 0, 12'h020, 32'h0,        1, 0, 0, 32'h0,        1, 32'hA5A50020};
    vt[7]  = '{1, 0, 12'h010, 32'h0,        1, 0, 0, 12'h020, 32'h0,        0, 1, 1, 32'hDEADBEEF, 0, 32'h0};
    vt[8]  = '{1, 1, 12'h030, 32'h0BADF00D, 0, 0, 0, 12'h000, 32'h0,        1, 0, 0, 32'h0,        1, 32'hA5A50020};
    vt[9]  = '{1, 0, 12'h0FF, 32'h0,        1, 1, 0, 12'h0FF, 32'h12345678, 0, 1, 0, 32'h0,        0, 32'h0};
    vt[10] = '{1, 0, 12'h0FF, 32'h0,        0, 0, 0, 12'h000, 32'h0,        1, 0, 0, 32'h0,        0, 32'h0};
    vt[11] = '{0, 0, 12'h000, 32'h0,        0, 0, 0, 12'h000, 32'h0,        0, 0, 1, 32'h12345678, 0, 32'h0};

    reset = 1;
    idle_inputs();
    do_reset();

    // Directed vectors: write/read, alternating ties, cross-requester visibility
    for (int i = 0; i < 12; i++) begin
      cpu_req = vt[i].cr; cpu_wEn = vt[i].cw; cpu_addr = vt[i].ca; cpu_dataIn = vt[i].cd;
      aux_req = vt[i].ar; aux_wEn = vt[i].aw; aux_lock = vt[i].al;
      aux_addr = vt[i].aa; aux_dataIn = vt[i].ad;
      run_cycle(gc, ga);
      chk($sformatf("vec%0d_gnt", i), {s_cg, s_ag}, {vt[i].ecg, vt[i].eag});
      chk($sformatf("vec%0d_rd", i), {s_crv, s_cdo, s_arv, s_ado},
          {vt[i].ecrv, vt[i].ecdo, vt[i].earv, vt[i].eado});
    end

    // Locked burst of full length with cpu waiting from the first locked grant
    do_reset();
    idle_inputs();
    cpu_req = 1; cpu_wEn = 1; cpu_addr = 12'h100; cpu_dataIn = 32'h00C0FFEE;
    run_cycle(gc, ga);
    cpu_wEn = 0; cpu_addr = 12'h010;
    aux_req = 1; aux_lock = 1; aux_wEn = 0;
    run = 0; stall_cnt = 0; got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      aux_addr = 12'(c);
      run_cycle(gc, ga);
      if (s_ag) run++;
      if (s_stall) stall_cnt++;
      if (s_cg) got = 1;
    end
    chk("burst_release_cpu_gnt", 128'(got), 128'd1);
    chk("burst_len", 128'(run), 128'(MB));
    chk("burst_stall_cycles", 128'(stall_cnt), 128'(MB));
    cpu_req = 0;
    run_cycle(gc, ga);
    chk("burst_restart_aux", {s_cg, s_ag}, 128'b01);
    idle_inputs();
    run_cycle(gc, ga);

    // Burst aborted by dropping the lock after three grants
    do_reset();
    idle_inputs();
    aux_req = 1; aux_lock = 1; aux_wEn = 1;
    for (int c = 0; c < 3; c++) begin
      aux_addr = 12'(12'h200 + c); aux_dataIn = 32'(c + 1);
      run_cycle(gc, ga);
      chk($sformatf("abort_lock_gnt%0d", c), 128'(s_ag), 128'd1);
    end
    aux_lock = 0; aux_addr = 12'h203; aux_dataIn = 32'h4;
    run_cycle(gc, ga);
    chk("abort_exit_no_gnt", {s_cg, s_ag}, 128'b00);
    run_cycle(gc, ga);
    chk("abort_unlocked_gnt", {s_cg, s_ag}, 128'b01);
    idle_inputs();
    aux_req = 1; aux_lock = 1; aux_wEn = 0; aux_addr = 12'h201;
    run = 0;
    for (int c = 0; c < MB + 1; c++) begin
      if (c == 1) begin cpu_req = 1; cpu_wEn = 0; cpu_addr = 12'h202; end
      run_cycle(gc, ga);
      if (s_ag && cpu_req) run++;
      if (s_cg) cpu_req = 0;
    end
    chk("abort_then_full_burst", 128'(run), 128'(MB - 1));
    idle_inputs();
    run_cycle(gc, ga);

    // Reset arriving right after a read grant drops the read
    do_reset();
    idle_inputs();
    cpu_req = 1; cpu_wEn = 0; cpu_addr = 12'h010;
    run_cycle(gc, ga);
    chk("rst_mid_rd_gnt", 128'(s_cg), 128'd1);
    reset = 1;
    cpu_addr = 12'h030; aux_req = 1; aux_wEn = 0; aux_addr = 12'h020;
    run_cycle(gc, ga);
    reset = 0;
    run_cycle(gc, ga);
    chk("rst_first_tie_cpu", {s_cg, s_ag, s_crv, s_arv}, 128'b1000);
    cpu_req = 0;
    run_cycle(gc, ga);
    chk("rst_post_read", {s_ag, s_crv, s_cdo}, {1'b1, 1'b1, 32'h0BADF00D});
    idle_inputs();
    run_cycle(gc, ga);

    // Randomised traffic against the reference model
    cp = 0; ap = 0;
    for (int n = 0; n < 600; n++) begin
      if (!cp) begin
        cpu_req = ($urandom_range(0, 2) != 0);
        cpu_wEn = 1'($urandom_range(0, 1));
        cpu_addr = 12'($urandom_range(0, 15));
        cpu_dataIn = $urandom;
      end
      if (!ap) begin
        aux_req = ($urandom_range(0, 2) != 0);
        aux_wEn = 1'($urandom_range(0, 1));
        aux_addr = 12'($urandom_range(0, 15));
        aux_dataIn = $urandom;
      end
      aux_lock = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 99) == 0);
      run_cycle(gc, ga);
      cp = cpu_req && !gc;
      ap = aux_req && !ga;
      reset = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
